// File: rtl/shift32_seq_if.sv
// shift32_seq_if: request/result bus between a client and the shift32_seq sequencer.
interface shift32_seq_if #(parameter int WIDTH = 16);
    logic             start;
    logic             dir;
    logic [4:0]       amt;
    logic [WIDTH-1:0] in_hi;
    logic [WIDTH-1:0] in_lo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    modport master (output start, dir, amt, in_hi, in_lo, input busy, done, res_hi, res_lo);
    modport slave (input start, dir, amt, in_hi, in_lo, output busy, done, res_hi, res_lo);
endinterface

// File: rtl/shift32_seq.sv
// shift32_seq: 32-bit logical shift of a hi:lo word pair built from up to three passes
// through a shared WIDTH-bit shifter, with merged partial results and a one-cycle done pulse.
module shift32_seq #(parameter int WIDTH = 16) (
    input  logic             clk,
    input  logic             reset_n,
    shift32_seq_if.slave     bus,
    output logic [3:0]       sh_opcode,
    output logic [3:0]       sh_amt,
    output logic [WIDTH-1:0] sh_srcA,
    output logic [WIDTH-1:0] sh_srcB,
    input  logic [WIDTH-1:0] sh_out
);
    typedef enum logic [2:0] {IDLE, P1, P2, P3, DONE} state_t;
    state_t           state, state_nxt;
    logic             accept, pass;
    logic             dir_q;
    logic [4:0]       amt_q;
    logic [WIDTH-1:0] hi_q, lo_q, acc_hi, acc_lo, res_hi, res_lo;
    logic             wr_near, wr_far, wr_hi, wr_lo;
    logic [WIDTH-1:0] near, mix;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        accept = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                accept = 1'b1;
                state_nxt = bus.amt == 5'd0 ? DONE : bus.amt[4] ? P3 : P1;
            end
            P1: state_nxt = P2;
            P2: state_nxt = P3;
            P3: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        pass = state == P1 || state == P2 || state == P3;
        // Left: P1/P3 shift left, P2 brings the spill across with a right shift; right mirrors it.
        sh_opcode = pass ? {3'b000, state == P2 ? dir_q : ~dir_q} : 4'h0;
        sh_amt = !pass ? 4'd0 : state == P2 ? 4'(5'd16 - amt_q) : amt_q[3:0];
        sh_srcA = !pass ? '0 : ((state == P1) == dir_q) ? hi_q : lo_q;
        sh_srcB = '0;
        // "Near" word is the one that receives the spill: hi for left, lo for right.
        near = dir_q ? acc_hi : acc_lo;
        wr_near = state == P1 || state == P2 || (state == P3 && amt_q[4]);
        wr_far = state == P3 && !amt_q[4];
        wr_hi = dir_q ? wr_near : wr_far;
        wr_lo = dir_q ? wr_far : wr_near;
        mix = (state == P2 ? near : '0) | sh_out;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            dir_q <= 1'b0;
            amt_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            if (accept) begin
                dir_q <= bus.dir;
                amt_q <= bus.amt;
                hi_q <= bus.in_hi;
                lo_q <= bus.in_lo;
                acc_hi <= bus.amt == 5'd0 ? bus.in_hi : '0;
                acc_lo <= bus.amt == 5'd0 ? bus.in_lo : '0;
            end else begin
                if (wr_hi) acc_hi <= mix;
                if (wr_lo) acc_lo <= mix;
            end
            if (state == DONE) begin
                res_hi <= acc_hi;
                res_lo <= acc_lo;
            end
        end
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.res_hi = res_hi;
    assign bus.res_lo = res_lo;
endmodule

// File: tb/tb_shift32_seq.sv
// tb_shift32_seq: directed vectors with a scoreboard; a monitor checks shifter passes,
// done latency and results against hand-computed expectations queued by the stimulus.
module tb_shift32_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  sh_opcode, sh_amt;
    logic [15:0] sh_srcA, sh_srcB, sh_out;
    int          tests = 0, fails = 0, cyc = 0;
    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t        exp_q[$];
    logic [23:0] pass_q[$];
    shift32_seq_if #(.WIDTH(16)) bus ();
    shift32_seq #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .sh_opcode(sh_opcode), .sh_amt(sh_amt), .sh_srcA(sh_srcA), .sh_srcB(sh_srcB), .sh_out(sh_out)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Shared shifter model: only opcodes 0 and 1 exist.
    assign sh_out = sh_opcode == 4'h0 ? sh_srcA << sh_amt : sh_opcode == 4'h1 ? sh_srcA >> sh_amt : 16'h0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic issue(input logic d, input logic [4:0] a, input logic [15:0] h, input logic [15:0] l,
                         input logic [31:0] res, input int lat, input logic [23:0] p0, input logic [23:0] p1,
                         input logic [23:0] p2, input int np, input bit push_res);
        exp_t e;
        logic [23:0] p[3];
        p[0] = p0; p[1] = p1; p[2] = p2;
        for (int i = 0; i < np; i++) pass_q.push_back(p[i]);
        e.res = res; e.lat = lat; e.acc = cyc + 1;
        if (push_res) exp_q.push_back(e);
        bus.dir = d; bus.amt = a; bus.in_hi = h; bus.in_lo = l; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        tests++; fails++;
        $display("FAIL idle_timeout: busy still %b after 40 cycles, required 0", bus.busy);
    endtask
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus.busy && !bus.done) begin
            if (pass_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL pass_extra: shifter pass %h/%h/%h, required none", sh_opcode, sh_amt, sh_srcA);
            end else chk("pass", {sh_opcode, sh_amt, sh_srcA}, 64'(pass_q.pop_front()));
        end
        if (bus.done) begin
            chk("sh_zero_done", {sh_opcode, sh_amt, sh_srcA, sh_srcB}, 64'h0);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL done_extra: done=1, required no completion");
            end else begin
                e = exp_q.pop_front();
                chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                @(negedge clk);
                chk("result", {bus.res_hi, bus.res_lo}, 64'(e.res));
            end
        end
    end
    initial begin
        exp_t e;
        int n;
        bus.start = 1'b0; bus.dir = 1'b0; bus.amt = 5'd0; bus.in_hi = 16'h0; bus.in_lo = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy_done", {bus.busy, bus.done}, 64'h0);
        chk("rst_res", {bus.res_hi, bus.res_lo}, 64'h0);
        chk("rst_sh", {sh_opcode, sh_amt, sh_srcA, sh_srcB}, 64'h0);
        reset_n = 1'b1;
        @(negedge clk);
        issue(1'b1, 5'd4, 16'h1234, 16'hABCD, 32'h234A_BCD0, 4, {8'h04, 16'h1234}, {8'h1C, 16'hABCD}, {8'h04, 16'hABCD}, 3, 1);
        wait_idle();
        issue(1'b0, 5'd20, 16'h8001, 16'hFFFF, 32'h0000_0800, 2, {8'h14, 16'h8001}, 24'h0, 24'h0, 1, 1);
        wait_idle();
        issue(1'b1, 5'd0, 16'hDEAD, 16'hBEEF, 32'hDEAD_BEEF, 1, 24'h0, 24'h0, 24'h0, 0, 1);
        wait_idle();
        issue(1'b1, 5'd16, 16'hFFFF, 16'h00A5, 32'h00A5_0000, 2, {8'h00, 16'h00A5}, 24'h0, 24'h0, 1, 1);
        wait_idle();
        issue(1'b0, 5'd31, 16'h8000, 16'h0000, 32'h0000_0001, 2, {8'h1F, 16'h8000}, 24'h0, 24'h0, 1, 1);
        wait_idle();
        // Start held high through a 3-pass op: operands change while busy and must be ignored.
        pass_q.push_back({8'h14, 16'hABCD}); pass_q.push_back({8'h0C, 16'h1234}); pass_q.push_back({8'h14, 16'h1234});
        e.res = 32'h0123_4ABC; e.lat = 4; e.acc = cyc + 1;
        exp_q.push_back(e);
        bus.dir = 1'b0; bus.amt = 5'd4; bus.in_hi = 16'h1234; bus.in_lo = 16'hABCD; bus.start = 1'b1;
        @(negedge clk);
        bus.dir = 1'b1; bus.amt = 5'd8; bus.in_hi = 16'hFFFF; bus.in_lo = 16'hFFFF;
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("spam_done_seen", 64'(bus.done), 64'h1);
        pass_q.push_back({8'h01, 16'h8000}); pass_q.push_back({8'h1F, 16'h8001}); pass_q.push_back({8'h01, 16'h8001});
        e.res = 32'h0001_0002; e.lat = 4; e.acc = cyc + 2;
        exp_q.push_back(e);
        bus.dir = 1'b1; bus.amt = 5'd1; bus.in_hi = 16'h8000; bus.in_lo = 16'h8001;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        @(negedge clk);
        // Abort in P2: no completion is queued, only the two passes that happen.
        issue(1'b1, 5'd4, 16'h1234, 16'hABCD, 32'h0, 0, {8'h04, 16'h1234}, {8'h1C, 16'hABCD}, 24'h0, 2, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy_done", {bus.busy, bus.done}, 64'h0);
        chk("abort_res", {bus.res_hi, bus.res_lo}, 64'h0);
        chk("abort_sh", {sh_opcode, sh_amt, sh_srcA, sh_srcB}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 5'd1, 16'h0001, 16'h0000, 32'h0000_8000, 4, {8'h11, 16'h0000}, {8'h0F, 16'h0001}, {8'h11, 16'h0001}, 3, 1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("exp_q_empty", 64'(exp_q.size()), 64'h0);
        chk("pass_q_empty", 64'(pass_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shift32_seq.md
# shift32_seq

Multi-cycle sequencer that runs 32-bit logical shifts of a register pair (hi:lo) on the shared 16-bit logical shifter. It accepts one request at a time, drives the shifter's opcode/amount/operand inputs for up to three passes, merges the partial results in internal registers, and reports the 32-bit result with a one-cycle done pulse. It sits beside the execute-stage datapath and handles double-word shift instructions. Single-word shifts keep using the shifter directly.

## Interface
- WIDTH, 16, width of one word and of the shifter datapath
- clk  in  1  rising-edge clock; only clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- dir  in  1  1 = shift left, 0 = shift right (logical, zero fill)
- amt  in  5  shift amount 0..31
- in_hi, in_lo  in  WIDTH each  operand upper/lower word
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse; result valid
- res_hi, res_lo  out  WIDTH each  registered result, held until next accepted start
- sh_opcode  out  4  to shifter: 4'h0 = shift left immediate, 4'h1 = shift right immediate
- sh_amt  out  4  to shifter shift amount
- sh_srcA  out  WIDTH  to shifter operand
- sh_srcB  out  WIDTH  to shifter; tied to 0
- sh_out  in  WIDTH  shifter result, combinational from the sh_* outputs

## Operation
- States: IDLE, P1, P2, P3, DONE.
- In IDLE, start=1 latches dir, amt, in_hi and in_lo. It clears an internal accumulator.
- Next state depends on amt:
  - amt=0 → DONE.
  - amt≥16 → P3.
  - 1..15 → P1.
- Let n = amt.
- Left shift, n in 1..15:
  - P1: sh_srcA=hi, sh_opcode=0, sh_amt=n; capture as acc_hi.
  - P2: sh_srcA=lo, sh_opcode=1, sh_amt=16−n; OR the result into acc_hi.
  - P3: sh_srcA=lo, sh_opcode=0, sh_amt=n; capture as acc_lo.
- Left shift, n≥16:
  - P3: sh_srcA=lo, sh_opcode=0, sh_amt=n−16; capture as acc_hi.
  - acc_lo=0.
- Right shift, n in 1..15 (mirror of left):
  - P1: sh_srcA=lo, sh_opcode=1, sh_amt=n; capture as acc_lo.
  - P2: sh_srcA=hi, sh_opcode=0, sh_amt=16−n; OR the result into acc_lo.
  - P3: sh_srcA=hi, sh_opcode=1, sh_amt=n; capture as acc_hi.
- Right shift, n≥16:
  - P3: sh_srcA=hi, sh_opcode=1, sh_amt=n−16; capture as acc_lo.
  - acc_hi=0.
- amt=0: acc = latched operands; this is a pass-through.
- P1→P2→P3→DONE unconditionally.
- DONE:
  - Copy acc to res_hi/res_lo and assert done.
  - Return to IDLE.
- sh_amt is always 0..15. 16−n for n in 1..15 fits in 4 bits.
- Outside P1–P3, the sh_* outputs are all zero (opcode 4'h0, amt 0, srcA 0).
- start while busy is ignored, not queued. start and done in the same cycle is not possible, because done is only asserted in DONE, which is not IDLE.

## Timing
- Reset (async assert, sync release) forces:
  - state = IDLE
  - busy = 0, done = 0
  - res_hi = res_lo = 0
  - accumulators = 0
  - all sh_* = 0
- Start accepted at edge T (start high in cycle T−1, state IDLE).
- Cycle in which done is high:
  - amt=0: cycle T (DONE state).
  - amt≥16: P3 in cycle T, done in cycle T+1.
  - amt 1..15: P1/P2/P3 in cycles T..T+2, done in cycle T+3.
- busy is high in every non-IDLE state, including DONE. It is low in IDLE.
- res_* update on the edge that leaves DONE. They are visible in the cycle after the done pulse and stay stable until the next completion.
- The next start may be presented in the cycle after done, once the state is back in IDLE.
- reset_n low mid-operation aborts immediately:
  - no done pulse is produced
  - res_* return to 0

## Test plan
- Left, amt=4, in_hi=0x1234, in_lo=0xABCD → res_hi=0x234A, res_lo=0xBCD0. done exactly 4 cycles after acceptance. Passes observed on sh_*: (0,4,0x1234), (1,12,0xABCD), (0,4,0xABCD).
- Right, amt=20, in_hi=0x8001, in_lo=0xFFFF → res_hi=0x0000, res_lo=0x0800. Single pass (1,4,0x8001). done 2 cycles after acceptance.
- amt=0, in_hi=0xDEAD, in_lo=0xBEEF → result unchanged (0xDEAD/0xBEEF). No shifter pass; sh_* stay 0. done 1 cycle after acceptance.
- Left, amt=16, in_hi=0xFFFF, in_lo=0x00A5 → res_hi=0x00A5, res_lo=0x0000. Right, amt=31, in_hi=0x8000, in_lo=0 → res_lo=0x0001, res_hi=0.
- Start pulses every cycle during a 3-pass op → only the first is executed. Exactly one done. The next accepted start is the one after the return to IDLE.
- Assert reset_n low during P2 → busy, done, res_* and sh_* go to 0 asynchronously. After release, a fresh right shift by 1 of 0x0001_0000 gives res_hi=0x0000, res_lo=0x8000.
